// File: rtl/cursor_addr_counter.sv
// Address/cursor counter stepped by debounced inc/dec button levels, with
// wrap or saturate at the ends, parallel load and hold-to-auto-repeat.
module cursor_addr_counter #(
  parameter int WIDTH         = 4,
  parameter int MAX_VAL       = 8,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] addr,
  output logic             wrap_pulse,
  output logic             at_min,
  output logic             at_max
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [WIDTH-1:0] MAX_ADDR  = WIDTH'(MAX_VAL);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             wrap_q, wrap_d;
  logic             prev_inc_q, prev_dec_q;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

  logic             rise_inc, rise_dec, single_rise, held_ok;
  logic             do_step, step_up;
  logic [WIDTH-1:0] step_addr;
  logic             step_wrap;

  assign rise_inc    = btn_inc & ~prev_inc_q;
  assign rise_dec    = btn_dec & ~prev_dec_q;
  assign single_rise = rise_inc ^ rise_dec;
  // The held direction is only valid while its button alone is pressed.
  assign held_ok     = dir_up_q ? (btn_inc & ~btn_dec) : (btn_dec & ~btn_inc);

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    rep_cnt_d = rep_cnt_q;
    do_step   = 1'b0;
    step_up   = dir_up_q;
    if (clr || load || !en || (rise_inc && rise_dec)) begin
      state_d   = S_IDLE;
      rep_cnt_d = '0;
    end else if (single_rise) begin
      do_step   = 1'b1;
      step_up   = rise_inc;
      dir_up_d  = rise_inc;
      rep_cnt_d = '0;
      state_d   = ((REPEAT_EN != 0) && !(btn_inc && btn_dec)) ? S_HOLD : S_IDLE;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (!held_ok) begin
            state_d   = S_IDLE;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == HOLD_LAST) begin
            do_step   = 1'b1;
            state_d   = S_REPEAT;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!held_ok) begin
            state_d   = S_IDLE;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == REP_LAST) begin
            do_step   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = S_IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_addr = addr_q;
    step_wrap = 1'b0;
    if (step_up) begin
      if (addr_q == MAX_ADDR) begin
        if (WRAP != 0) begin
          step_addr = '0;
          step_wrap = 1'b1;
        end
      end else begin
        step_addr = addr_q + WIDTH'(1);
      end
    end else begin
      if (addr_q == '0) begin
        if (WRAP != 0) begin
          step_addr = MAX_ADDR;
          step_wrap = 1'b1;
        end
      end else begin
        step_addr = addr_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (clr) begin
      addr_d = '0;
    end else if (load) begin
      addr_d = (load_val > MAX_ADDR) ? MAX_ADDR : load_val;
    end else if (do_step) begin
      addr_d = step_addr;
      wrap_d = step_wrap;
    end
  end

  // Edge registers track the buttons in every non-reset cycle so that a
  // button held across clr, load or en=0 never produces a late step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wrap_q     <= 1'b0;
      prev_inc_q <= 1'b0;
      prev_dec_q <= 1'b0;
      dir_up_q   <= 1'b0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wrap_q     <= wrap_d;
      prev_inc_q <= btn_inc;
      prev_dec_q <= btn_dec;
      dir_up_q   <= dir_up_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign addr       = addr_q;
  assign wrap_pulse = wrap_q;
  assign at_min     = (addr_q == '0);
  assign at_max     = (addr_q == MAX_ADDR);

endmodule

// File: tb/tb_cursor_addr_counter.sv
// Directed bench for cursor_addr_counter: a wrapping and a saturating instance
// share stimulus and are checked every cycle against a run-length model.
module tb_cursor_addr_counter;

  localparam int W    = 4;
  localparam int MAXV = 8;
  localparam int HOLD = 4;
  localparam int REP  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0, clr = 1'b0, en = 1'b0;
  logic         btn_inc = 1'b0, btn_dec = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] addr_w, addr_s;
  logic         wrap_w, wrap_s, min_w, min_s, max_w, max_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cursor_addr_counter #(.WIDTH(W), .MAX_VAL(MAXV), .WRAP(1), .HOLD_CYCLES(HOLD),
                        .REPEAT_CYCLES(REP), .REPEAT_EN(1)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .load(load), .load_val(load_val), .addr(addr_w), .wrap_pulse(wrap_w),
    .at_min(min_w), .at_max(max_w));

  cursor_addr_counter #(.WIDTH(W), .MAX_VAL(MAXV), .WRAP(0), .HOLD_CYCLES(HOLD),
                        .REPEAT_CYCLES(REP), .REPEAT_EN(1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .load(load), .load_val(load_val), .addr(addr_s), .wrap_pulse(wrap_s),
    .at_min(min_s), .at_max(max_s));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a step happens on a single qualified rise, then on the held-run
  // cycles HOLD+2, HOLD+2+REP, ... counted from the rise cycle (cycle 1).
  int m_addr_w = 0, m_addr_s = 0, run_len = 0;
  bit m_wrap_w = 0, m_prev_inc = 0, m_prev_dec = 0, run_up = 0, live = 0;

  always @(posedge clk) begin
    bit ri, rd, step, up;
    int lv;
    ri = btn_inc && !m_prev_inc;
    rd = btn_dec && !m_prev_dec;
    step = 0;
    up = 0;
    m_wrap_w = 0;
    if (rst) begin
      m_addr_w = 0; m_addr_s = 0; run_len = 0; m_prev_inc = 0; m_prev_dec = 0;
      live = 1;
    end else begin
      lv = int'(load_val);
      if (clr) begin
        m_addr_w = 0; m_addr_s = 0; run_len = 0;
      end else if (load) begin
        m_addr_w = (lv > MAXV) ? MAXV : lv;
        m_addr_s = m_addr_w;
        run_len = 0;
      end else if (!en || (ri && rd)) begin
        run_len = 0;
      end else if (ri || rd) begin
        step = 1; up = ri; run_up = ri;
        run_len = (btn_inc && btn_dec) ? 0 : 1;
      end else if (run_len > 0 && (run_up ? (btn_inc && !btn_dec) : (btn_dec && !btn_inc))) begin
        run_len++;
        if (run_len >= HOLD + 2 && ((run_len - HOLD - 2) % REP) == 0) begin
          step = 1; up = run_up;
        end
      end else begin
        run_len = 0;
      end
      if (step) begin
        if (up) begin
          if (m_addr_w == MAXV) begin m_addr_w = 0; m_wrap_w = 1; end
          else m_addr_w++;
          if (m_addr_s < MAXV) m_addr_s++;
        end else begin
          if (m_addr_w == 0) begin m_addr_w = MAXV; m_wrap_w = 1; end
          else m_addr_w--;
          if (m_addr_s > 0) m_addr_s--;
        end
      end
      m_prev_inc = btn_inc;
      m_prev_dec = btn_dec;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("addr_w", int'(addr_w), m_addr_w);
      chk("wrap_w", int'(wrap_w), int'(m_wrap_w));
      chk("min_w", int'(min_w), int'(m_addr_w == 0));
      chk("max_w", int'(max_w), int'(m_addr_w == MAXV));
      chk("addr_s", int'(addr_s), m_addr_s);
      chk("wrap_s", int'(wrap_s), 0);
      chk("min_s", int'(min_s), int'(m_addr_s == 0));
      chk("max_s", int'(max_s), int'(m_addr_s == MAXV));
    end
  end

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = W'(v);
    cyc();
    load = 1'b0;
  endtask

  int hold_tab[12] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5};

  initial begin
    rst = 1'b1;
    cyc(2);
    rst = 1'b0; en = 1'b1;
    cyc();
    $display("reset: addr_w=%0d addr_s=%0d", addr_w, addr_s);
    chk("rst_addr", int'(addr_w), 0);
    chk("rst_min", int'(min_w), 1);
    chk("rst_max", int'(max_w), 0);

    // 9 single-cycle increment pulses: 1..8 then wrap to 0
    for (int i = 1; i <= 9; i++) begin
      btn_inc = 1'b1;
      cyc();
      $display("inc pulse %0d: addr_w=%0d wrap_w=%0d addr_s=%0d", i, addr_w, wrap_w, addr_s);
      chk("t1_addr", int'(addr_w), i % 9);
      chk("t1_wrap", int'(wrap_w), int'(i == 9));
      chk("t1_max", int'(max_w), int'(i == 8));
      btn_inc = 1'b0;
      cyc();
    end
    chk("t1_sat", int'(addr_s), 8);

    // saturating instance at 0 ignores a decrement; wrapping one goes to 8
    do_load(0);
    btn_dec = 1'b1; cyc();
    $display("dec at 0: addr_w=%0d addr_s=%0d", addr_w, addr_s);
    chk("t2_s0", int'(addr_s), 0);
    chk("t2_w8", int'(addr_w), 8);
    chk("t2_wrapw", int'(wrap_w), 1);
    btn_dec = 1'b0; cyc();
    for (int i = 0; i < 10; i++) begin
      btn_inc = 1'b1; cyc();
      btn_inc = 1'b0; cyc();
    end
    $display("10 inc: addr_w=%0d addr_s=%0d", addr_w, addr_s);
    chk("t2_ssat", int'(addr_s), 8);
    chk("t2_w", int'(addr_w), 0);

    // hold-to-repeat from 0: steps on held cycles 1, 6, 8, 10, 12
    do_load(0);
    btn_inc = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("t3_hold", int'(addr_w), hold_tab[k]);
    end
    $display("hold 12: addr_w=%0d", addr_w);
    btn_inc = 1'b0;
    cyc(4);
    chk("t3_release", int'(addr_w), 5);

    // simultaneous rise: no step; held inc plus rising dec: dec steps
    btn_inc = 1'b1; btn_dec = 1'b1;
    cyc();
    chk("t4_both", int'(addr_w), 5);
    cyc(6);
    chk("t4_bothheld", int'(addr_w), 5);
    btn_inc = 1'b0; btn_dec = 1'b0; cyc();
    load = 1'b1; load_val = 4'd3; btn_inc = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("t4_load3", int'(addr_w), 3);
    btn_dec = 1'b1; cyc();
    $display("inc held, dec rise: addr_w=%0d", addr_w);
    chk("t4_dec", int'(addr_w), 2);
    cyc(6);
    chk("t4_norep", int'(addr_w), 2);
    btn_inc = 1'b0; btn_dec = 1'b0; cyc();

    // load clamps; clr beats load and a held button does not step after clr
    do_load(13);
    $display("load 13: addr_w=%0d addr_s=%0d", addr_w, addr_s);
    chk("t5_clamp_w", int'(addr_w), 8);
    chk("t5_clamp_s", int'(addr_s), 8);
    load = 1'b1; clr = 1'b1; load_val = 4'd5; btn_inc = 1'b1;
    cyc();
    chk("t5_clr", int'(addr_w), 0);
    load = 1'b0; clr = 1'b0;
    cyc(6);
    $display("clr drop, inc held: addr_w=%0d", addr_w);
    chk("t5_nostep", int'(addr_w), 0);
    btn_inc = 1'b0; cyc();

    // en=0 blocks steps; a button held as en rises does not step
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1; cyc();
      btn_inc = 1'b0; cyc();
    end
    chk("t6_en0", int'(addr_w), 0);
    btn_inc = 1'b1; cyc();
    en = 1'b1; cyc(6);
    chk("t6_enrise", int'(addr_w), 0);
    btn_inc = 1'b0; cyc();

    // decrement repeat with wrap: 0 -> 8 -> 7 -> 6
    btn_dec = 1'b1; cyc(8);
    $display("dec hold 8: addr_w=%0d addr_s=%0d", addr_w, addr_s);
    chk("t6_decrep", int'(addr_w), 6);
    btn_dec = 1'b0; cyc();

    // rst mid-repeat with the button held
    do_load(0);
    btn_inc = 1'b1; cyc(9);
    chk("t6_rep3", int'(addr_w), 3);
    rst = 1'b1; cyc();
    chk("t6_rst", int'(addr_w), 0);
    cyc(5);
    chk("t6_rstheld", int'(addr_w), 0);
    btn_inc = 1'b0; cyc();
    rst = 1'b0; cyc(2);
    $display("after rst: addr_w=%0d at_min=%0d", addr_w, min_w);
    chk("t6_final", int'(addr_w), 0);
    chk("t6_min", int'(min_w), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
